mdu_hilo: RTL

- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Sits directly downstream of the register file and consumes its two read ports (rs, rt operands).
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and reports busy/done so the pipeline control can stall MFHI/MFLO.
- Also services MTHI/MTLO writes and supplies HI/LO to the write-back mux.

---
 rtl/mdu_hilo.sv | 97 +++++++++
 1 files changed

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             SYS_reset,
  input  logic             MDU_start,
  input  logic [1:0]       MDU_op,
  input  logic [WIDTH-1:0] MDU_rs_in,
  input  logic [WIDTH-1:0] MDU_rt_in,
  input  logic             MDU_mthi,
  input  logic             MDU_mtlo,
  output logic [WIDTH-1:0] MDU_hi,
  output logic [WIDTH-1:0] MDU_lo,
  output logic             MDU_busy,
  output logic             MDU_done
);
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a;
  logic [2*WIDTH-1:0] prod;
  logic sign_q, sign_r, is_div;
  logic signed_op;
  logic [WIDTH-1:0] abs_rs, abs_rt;
  logic [WIDTH:0] mul_sum, rem_x, diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  always_comb begin
    signed_op = ~MDU_op[0];
    abs_rs    = (signed_op && MDU_rs_in[WIDTH-1]) ? -MDU_rs_in : MDU_rs_in;
    abs_rt    = (signed_op && MDU_rt_in[WIDTH-1]) ? -MDU_rt_in : MDU_rt_in;
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a} : '0);
    // {rem, quot} shifted left by one: the new remainder candidate is 33 bits
    rem_x     = prod[2*WIDTH-1:WIDTH-1];
    diff      = rem_x - {1'b0, a};
    prod_fix  = sign_q ? -prod : prod;
    quot_fix  = sign_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    rem_fix   = sign_r ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    MDU_busy  = (state == MUL) || (state == DIV) || (state == FIX);
    MDU_done  = (state == DONE);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = MDU_start ? (MDU_op[1] ? DIV : MUL) : IDLE;
      MUL:     state_n = (cnt == CNT_W'(1)) ? FIX : MUL;
      DIV:     state_n = (cnt == CNT_W'(1)) ? FIX : DIV;
      FIX:     state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state  <= IDLE;
      MDU_hi <= '0;
      MDU_lo <= '0;
      cnt    <= '0;
      a      <= '0;
      prod   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      is_div <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (MDU_mthi) MDU_hi <= MDU_rs_in;
          if (MDU_mtlo) MDU_lo <= MDU_rs_in;
          if (MDU_start) begin
            a      <= abs_rt;
            prod   <= {{WIDTH{1'b0}}, abs_rs};
            cnt    <= CNT_W'(WIDTH);
            sign_q <= signed_op & (MDU_rs_in[WIDTH-1] ^ MDU_rt_in[WIDTH-1]);
            sign_r <= signed_op & MDU_rs_in[WIDTH-1];
            is_div <= MDU_op[1];
          end
        end
        MUL: begin
          prod <= {mul_sum, prod[WIDTH-1:1]};
          cnt  <= cnt - 1'b1;
        end
        DIV: begin
          prod <= diff[WIDTH] ? {rem_x[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                              : {diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
          cnt  <= cnt - 1'b1;
        end
        FIX: begin
          MDU_hi <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          MDU_lo <= is_div ? quot_fix : prod_fix[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule
